// File: rtl/intersection_light_ctrl_pkg.sv
// intersection_light_ctrl_pkg: shared state encoding and phase arithmetic for the intersection controller
package intersection_light_ctrl_pkg;
   localparam int ST_W = 2;
   typedef enum logic [ST_W-1:0] {
      ALL_RED = 2'd0,
      GREEN   = 2'd1,
      YELLOW  = 2'd2,
      FLASH   = 2'd3
   } state_t;
   // Modulo increment written as a compare so non-power-of-2 phase counts wrap correctly
   function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction
endpackage

// File: rtl/intersection_light_ctrl_sec_tick_gen.sv
// sec_tick_gen: one-cycle pulse every CL_PERIOD_TIME enabled clocks; en low holds the count
module sec_tick_gen #(
   parameter int CL_PERIOD_TIME = 100
) (
   input  logic clk,
   input  logic rstb,
   input  logic en,
   output logic sec_tick
);
   localparam int PW = (CL_PERIOD_TIME > 1) ? $clog2(CL_PERIOD_TIME) : 1;
   logic [PW-1:0] r_pre;
   logic          w_tc;
   assign w_tc     = (r_pre == PW'(CL_PERIOD_TIME - 1));
   assign sec_tick = en && w_tc;
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) r_pre <= '0;
      else if (en) r_pre <= w_tc ? '0 : r_pre + PW'(1);
   end
endmodule

// File: rtl/intersection_light_ctrl.sv
// intersection_light_ctrl: round-robin multi-phase signal controller with pedestrian walk extension
// and night flash; lamps are registered from the next-state values so they align with cnt_out.
module intersection_light_ctrl
   import intersection_light_ctrl_pkg::*;
#(
   parameter int CL_PERIOD_TIME = 100,
   parameter int NUM_PHASES     = 2,
   parameter int GREEN_TIME     = 15,
   parameter int YELLOW_TIME    = 3,
   parameter int ALLRED_TIME    = 1,
   parameter int WALK_EXT       = 5,
   parameter int PH_W           = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
   parameter int CNT_W          = $clog2(GREEN_TIME + WALK_EXT + 1)
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  en,
   input  logic                  flash_mode,
   input  logic [NUM_PHASES-1:0] ped_req,
   output logic [NUM_PHASES-1:0] red,
   output logic [NUM_PHASES-1:0] yellow,
   output logic [NUM_PHASES-1:0] green,
   output logic [NUM_PHASES-1:0] walk,
   output logic [PH_W-1:0]       phase_idx,
   output logic [CNT_W-1:0]      cnt_out
);
   state_t                r_state, w_state;
   logic [CNT_W-1:0]      r_cnt, w_cnt;
   logic [PH_W-1:0]       r_phase, w_phase;
   logic [NUM_PHASES-1:0] r_pend, w_pend;
   logic                  r_grant, w_grant, r_tog, w_tog;
   logic [NUM_PHASES-1:0] r_red, r_yellow, r_green, r_walk;
   logic [NUM_PHASES-1:0] w_red, w_yellow, w_green, w_walk, w_oh;
   logic                  w_tick, w_last, w_req_now;

   sec_tick_gen #(.CL_PERIOD_TIME(CL_PERIOD_TIME)) u_tick (
      .clk      (clk),
      .rstb     (rstb),
      .en       (en),
      .sec_tick (w_tick)
   );

   assign w_last    = (r_cnt == CNT_W'(1));
   assign w_req_now = r_pend[r_phase] | ped_req[r_phase];

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_phase = r_phase;
      w_grant = r_grant;
      w_tog   = r_tog;
      w_pend  = en ? (r_pend | ped_req) : r_pend;
      if (w_tick) begin
         case (r_state)
            ALL_RED: begin
               if (!w_last) w_cnt = r_cnt - CNT_W'(1);
               else if (flash_mode) begin
                  w_state = FLASH;
                  w_cnt   = '0;
                  w_tog   = 1'b1;
               end else begin
                  w_state         = GREEN;
                  w_grant         = w_req_now;
                  w_cnt           = CNT_W'(GREEN_TIME) + (w_req_now ? CNT_W'(WALK_EXT) : '0);
                  w_pend[r_phase] = 1'b0;
               end
            end
            GREEN: begin
               if (!w_last) w_cnt = r_cnt - CNT_W'(1);
               else begin
                  w_state = YELLOW;
                  w_cnt   = CNT_W'(YELLOW_TIME);
                  w_grant = 1'b0;
               end
            end
            YELLOW: begin
               if (!w_last) w_cnt = r_cnt - CNT_W'(1);
               else begin
                  w_state = ALL_RED;
                  w_cnt   = CNT_W'(ALLRED_TIME);
                  w_phase = PH_W'(wrap_inc(32'(r_phase), NUM_PHASES));
               end
            end
            default: begin
               w_tog = ~r_tog;
               if (!flash_mode) begin
                  w_state = ALL_RED;
                  w_cnt   = CNT_W'(ALLRED_TIME);
                  w_tog   = 1'b0;
               end
            end
         endcase
      end
   end

   always_comb begin
      w_oh     = NUM_PHASES'(1) << w_phase;
      w_green  = (w_state == GREEN) ? w_oh : '0;
      w_walk   = (w_state == GREEN && w_grant) ? w_oh : '0;
      w_yellow = (w_state == YELLOW) ? w_oh : (w_state == FLASH) ? {NUM_PHASES{w_tog}} : '0;
      w_red    = (w_state == FLASH) ? '0 : (w_state == ALL_RED) ? '1 : ~w_oh;
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state  <= ALL_RED;
         r_cnt    <= CNT_W'(ALLRED_TIME);
         r_phase  <= '0;
         r_pend   <= '0;
         r_grant  <= 1'b0;
         r_tog    <= 1'b0;
         r_red    <= '1;
         r_yellow <= '0;
         r_green  <= '0;
         r_walk   <= '0;
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_phase  <= w_phase;
         r_pend   <= w_pend;
         r_grant  <= w_grant;
         r_tog    <= w_tog;
         r_red    <= w_red;
         r_yellow <= w_yellow;
         r_green  <= w_green;
         r_walk   <= w_walk;
      end
   end

   assign red       = r_red;
   assign yellow    = r_yellow;
   assign green     = r_green;
   assign walk      = r_walk;
   assign phase_idx = r_phase;
   assign cnt_out   = r_cnt;
endmodule

// File: tb/tb_intersection_light_ctrl.sv
// tb_intersection_light_ctrl: directed and randomized stimulus checked against a per-second
// behavioural model of the intersection schedule.
module tb_intersection_light_ctrl;
   localparam int CL = 4, N = 3, GT = 3, YT = 2, AT = 1, WE = 2;
   localparam int PH_W = 2, CNT_W = 3;
   localparam int M_AR = 0, M_G = 1, M_Y = 2, M_F = 3;

   logic             clk, rstb, en, flash_mode;
   logic [N-1:0]     ped_req, red, yellow, green, walk;
   logic [PH_W-1:0]  phase_idx;
   logic [CNT_W-1:0] cnt_out;

   int total = 0, bad = 0;
   int m_pre, m_st, m_left, m_ph, m_grant, m_tog;
   bit [N-1:0] m_pend;

   intersection_light_ctrl #(
      .CL_PERIOD_TIME(CL), .NUM_PHASES(N), .GREEN_TIME(GT), .YELLOW_TIME(YT),
      .ALLRED_TIME(AT), .WALK_EXT(WE)
   ) dut (
      .clk(clk), .rstb(rstb), .en(en), .flash_mode(flash_mode), .ped_req(ped_req),
      .red(red), .yellow(yellow), .green(green), .walk(walk),
      .phase_idx(phase_idx), .cnt_out(cnt_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pre = 0; m_st = M_AR; m_left = AT; m_ph = 0; m_grant = 0; m_tog = 0; m_pend = '0;
   endtask

   task automatic model_step(input bit e, input bit fm, input bit [N-1:0] pr);
      bit tick;
      if (!e) return;
      tick  = (m_pre == CL - 1);
      m_pre = tick ? 0 : m_pre + 1;
      m_pend = m_pend | pr;
      if (!tick) return;
      if (m_st == M_F) begin
         m_tog = !m_tog;
         if (!fm) begin m_st = M_AR; m_left = AT; m_tog = 0; end
         return;
      end
      if (m_left > 1) begin m_left--; return; end
      case (m_st)
         M_AR: if (fm) begin
            m_st = M_F; m_tog = 1; m_left = 0;
         end else begin
            m_grant = m_pend[m_ph]; m_pend[m_ph] = 0;
            m_st = M_G; m_left = GT + (m_grant ? WE : 0);
         end
         M_G: begin m_st = M_Y; m_left = YT; m_grant = 0; end
         default: begin m_ph = (m_ph + 1) % N; m_st = M_AR; m_left = AT; end
      endcase
   endtask

   task automatic compare_all();
      logic [N-1:0] er, ey, eg, ew;
      for (int p = 0; p < N; p++) begin
         eg[p] = (m_st == M_G) && (p == m_ph);
         ew[p] = eg[p] && (m_grant != 0);
         ey[p] = ((m_st == M_Y) && (p == m_ph)) || ((m_st == M_F) && (m_tog != 0));
         er[p] = (m_st != M_F) && !eg[p] && !((m_st == M_Y) && (p == m_ph));
      end
      check("red", 32'(red), 32'(er));
      check("yellow", 32'(yellow), 32'(ey));
      check("green", 32'(green), 32'(eg));
      check("walk", 32'(walk), 32'(ew));
      check("phase", 32'(phase_idx), 32'(m_ph));
      check("cnt", 32'(cnt_out), 32'(m_left));
   endtask

   task automatic cyc(input bit e, input bit fm, input bit [N-1:0] pr);
      en = e; flash_mode = fm; ped_req = pr;
      model_step(e, fm, pr);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic wait_for(input int st, input int ph, input string tag);
      int n = 0;
      while (!(m_st == st && m_ph == ph) && n < 400) begin
         cyc(1, 0, '0);
         n++;
      end
      check(tag, 32'(phase_idx), 32'(ph));
      check({tag, "_bound"}, 32'(n < 400), 32'(1));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_red"}, 32'(red), 32'(3'b111));
      check({tag, "_yel"}, 32'(yellow), 32'(0));
      check({tag, "_grn"}, 32'(green), 32'(0));
      check({tag, "_walk"}, 32'(walk), 32'(0));
      check({tag, "_ph"}, 32'(phase_idx), 32'(0));
      check({tag, "_cnt"}, 32'(cnt_out), 32'(AT));
   endtask

   initial begin
      clk = 0; rstb = 0; en = 0; flash_mode = 0; ped_req = '0;
      model_reset();
      #12;
      check_reset_vals("rst");
      @(negedge clk);
      rstb = 1;
      // one full round with phase wrap, no requests
      for (int i = 0; i < 90; i++) cyc(1, 0, '0);
      // walk request for phase 1 raised during G0
      wait_for(M_G, 0, "w_g0a");
      cyc(1, 0, 3'b010);
      for (int i = 0; i < 100; i++) cyc(1, 0, '0);
      // request for the phase currently green is held for its next green
      wait_for(M_G, 0, "w_g0b");
      cyc(1, 0, 3'b001);
      for (int i = 0; i < 100; i++) cyc(1, 0, '0);
      // flash mode raised during Y0
      wait_for(M_Y, 0, "w_y0");
      for (int i = 0; i < 60; i++) cyc(1, 1, '0);
      for (int i = 0; i < 40; i++) cyc(1, 0, '0);
      // enable pause mid-G2 with a request that must not be latched
      wait_for(M_G, 2, "w_g2");
      cyc(1, 0, '0);
      for (int i = 0; i < 10; i++) cyc(0, 0, (i == 5) ? 3'b111 : 3'b000);
      for (int i = 0; i < 80; i++) cyc(1, 0, '0);
      // randomized traffic, flash windows and enable drops
      for (int b = 0; b < 12; b++) begin
         bit fm;
         fm = ($urandom_range(0, 2) == 0);
         for (int i = 0; i < 60; i++)
            cyc($urandom_range(0, 9) != 0, fm,
                3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)));
      end
      // asynchronous reset mid-Y1 with requests pending
      wait_for(M_Y, 1, "w_y1");
      cyc(1, 0, 3'b111);
      #2;
      rstb = 0;
      #1;
      model_reset();
      check_reset_vals("arst");
      @(negedge clk);
      rstb = 1;
      for (int i = 0; i < 80; i++) cyc(1, 0, '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/intersection_light_ctrl.md
Name: intersection_light_ctrl

Overview:
- Multi-phase intersection controller; successor to the single-approach traffic light.
- Serves NUM_PHASES approaches round-robin: GREEN, then YELLOW, then an ALL_RED clearance interval.
- Adds latched pedestrian requests with walk grant and green extension, plus a night flash mode.
- Top-level light block: drives lamp outputs and a seconds countdown for the display driver.

Parameters:
- CL_PERIOD_TIME, 100: clk cycles per one-second tick.
- NUM_PHASES, 2: number of approaches, 2..8.
- GREEN_TIME, 15: base green seconds, >=1.
- YELLOW_TIME, 3: yellow seconds, >=1.
- ALLRED_TIME, 1: all-red clearance seconds, >=1.
- WALK_EXT, 5: extra green seconds when a walk is granted, >=0.
- PH_W, max(1,$clog2(NUM_PHASES)): phase index width.
- CNT_W, $clog2(GREEN_TIME+WALK_EXT+1): countdown width.

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous active-low reset
- en  in  1  global enable; low freezes prescaler, FSM and request capture
- flash_mode  in  1  night mode request, level
- ped_req  in  NUM_PHASES  pedestrian request per phase, pulse or level
- red  out  NUM_PHASES  red lamp per phase
- yellow  out  NUM_PHASES  yellow lamp per phase
- green  out  NUM_PHASES  green lamp per phase
- walk  out  NUM_PHASES  pedestrian walk lamp per phase
- phase_idx  out  PH_W  phase being served, or next to be served
- cnt_out  out  CNT_W  seconds remaining in current state

Behaviour:
- Reset values (async, rstb low):
  - state=ALL_RED, cnt_out=ALLRED_TIME, phase_idx=0.
  - red=all 1; yellow, green and walk=0.
  - ped pending bits=0, walk_grant=0, flash toggle=0, prescaler=0.
- Prescaler:
  - Counts 0..CL_PERIOD_TIME-1 while en=1.
  - sec_tick is a one-cycle pulse at terminal count, then wraps to 0.
  - en=0 holds the count and suppresses sec_tick.
- Countdown:
  - On sec_tick with cnt>1: decrement.
  - On sec_tick with cnt==1: transition and load the next duration in the same cycle.
  - Each state therefore lasts exactly N ticks; cnt_out shows N..1.
- ALL_RED to next state on expiry:
  - flash_mode=1: go to FLASH.
  - Otherwise: go to GREEN(phase_idx) and load GREEN_TIME, plus WALK_EXT if pend[phase_idx]|ped_req[phase_idx].
  - walk_grant is set to that condition; pend[phase_idx] clears.
- GREEN to YELLOW on expiry: load YELLOW_TIME, walk_grant cleared.
- YELLOW to ALL_RED on expiry: phase_idx=(phase_idx+1) mod NUM_PHASES (wrap at NUM_PHASES-1, non-power-of-2 safe); load ALLRED_TIME.
- FLASH:
  - red, green and walk=0; all yellow bits=flash toggle.
  - Toggle sets to 1 on entry and inverts each sec_tick.
  - cnt_out=0.
  - On a sec_tick with flash_mode=0: go to ALL_RED, load ALLRED_TIME, toggle=0, phase_idx unchanged.
- Flash entry/exit boundaries:
  - flash_mode asserted in GREEN or YELLOW completes the normal sequence first.
  - FLASH is entered only at ALL_RED expiry.
- Lamp decode (registered, one-hot per phase, from state/phase_idx):
  - GREEN: green[p]=1, walk[p]=walk_grant.
  - YELLOW: yellow[p]=1.
  - All other phase bits red=1; ALL_RED gives all red.
- Ped requests:
  - ped_req[i] sampled every clk while en=1 and sets sticky pend[i].
  - A request for the phase currently in GREEN or YELLOW stays pending for that phase's next green.
  - Request coincident with green entry for that phase: granted, pend ends 0.
  - Pend bits persist through FLASH; en=0 ignores requests.
- Mid-operation rstb assertion: immediate return to the reset values; no partial state retained.

Decomposition:
- Shared package: state encoding (ALL_RED, GREEN, YELLOW, FLASH), 2-bit localparams.
- Sub-module: sec_tick_gen, parametrised by CL_PERIOD_TIME, ports clk/rstb/en/sec_tick.
- FSM, countdown, pend bits and lamp decode stay in the top.

Test Plan (CL_PERIOD_TIME=4, NUM_PHASES=3, GREEN=3, YELLOW=2, ALLRED=1, WALK_EXT=2):
- Reset release, en=1, no requests -> sequence ALLRED(1)->G0(3,2,1)->Y0(2,1)->ALLRED->G1->...->G2->G0; phase_idx wraps 2->0; 4 clk per cnt step.
- ped_req[1] one-cycle pulse during G0 -> G1 lasts 5 s, walk[1]=1 throughout G1 only, walk=0 in Y1; next G1 lasts 3 s.
- ped_req[0] pulse during G0 -> G0 unchanged; next G0 is 5 s with walk[0]=1.
- flash_mode=1 during Y0 -> Y0 completes, ALLRED 1 s, then FLASH with yellow=3'b111/3'b000 alternating per tick and cnt_out=0. Drop flash_mode -> ALLRED at next tick, then G1.
- en=0 for 10 clk mid-G2 -> outputs and cnt_out frozen; a ped_req pulse during this window is not latched. Resume continues from the same prescaler count.
- rstb low mid-Y1 -> outputs are the reset values within the same cycle (asynchronous); pend bits cleared.
